// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional ADDI support is enabled by defining MC_MAIN_CTRL_ADDI_EN.
module mc_main_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic [1:0] aluOp,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic       iorD,
   output logic       memRead,
   output logic       memWrite,
   output logic       irWrite,
   output logic       pcWrite,
   output logic       pcWriteCond,
   output logic [1:0] pcSource,
   output logic       regWrite,
   output logic       regDst,
   output logic       memtoReg,
   output logic       illegal_op,
   output logic [3:0] state
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_MAIN_CTRL_ADDI_EN
   localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      MEMADR = 4'd3,
      MEMRD  = 4'd4,
      MEMWB  = 4'd5,
      MEMWR  = 4'd6,
      EXEC   = 4'd7,
      RWB    = 4'd8,
      BEQ    = 4'd9,
      JMP    = 4'd10
`ifdef MC_MAIN_CTRL_ADDI_EN
      ,
      ADDIEX = 4'd11,
      ADDIWB = 4'd12
`endif
   } stateType;

   stateType stateQ;
   stateType stateNext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ <= IDLE;
      end else begin
         stateQ <= stateNext;
      end
   end

   assign state = stateQ;

   always_comb begin
      stateNext   = stateQ;
      aluOp       = 2'b00;
      aluSrcA     = 1'b0;
      aluSrcB     = 2'b00;
      iorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      irWrite     = 1'b0;
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      pcSource    = 2'b00;
      regWrite    = 1'b0;
      regDst      = 1'b0;
      memtoReg    = 1'b0;
      illegal_op  = 1'b0;

      case (stateQ)
         IDLE: stateNext = FETCH;

         FETCH: begin
            memRead = 1'b1;
            aluSrcB = 2'b01;
            irWrite = mem_ready;
            pcWrite = mem_ready;
            if (mem_ready) stateNext = DECODE;
         end

         DECODE: begin
            aluSrcB = 2'b11;
            case (opcode)
               OP_LW, OP_SW: stateNext = MEMADR;
               OP_RTYPE:     stateNext = EXEC;
               OP_BEQ:       stateNext = BEQ;
               OP_J:         stateNext = JMP;
`ifdef MC_MAIN_CTRL_ADDI_EN
               OP_ADDI:      stateNext = ADDIEX;
`endif
               default: begin
                  illegal_op = 1'b1;
                  stateNext  = FETCH;
               end
            endcase
         end

         // Opcode is re-sampled here; anything other than LW/SW is treated as illegal.
         MEMADR: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
            if (opcode == OP_LW) begin
               stateNext = MEMRD;
            end else if (opcode == OP_SW) begin
               stateNext = MEMWR;
            end else begin
               illegal_op = 1'b1;
               stateNext  = FETCH;
            end
         end

         MEMRD: begin
            memRead = 1'b1;
            iorD    = 1'b1;
            if (mem_ready) stateNext = MEMWB;
         end

         MEMWB: begin
            regWrite  = 1'b1;
            memtoReg  = 1'b1;
            stateNext = FETCH;
         end

         MEMWR: begin
            memWrite = 1'b1;
            iorD     = 1'b1;
            if (mem_ready) stateNext = FETCH;
         end

         EXEC: begin
            aluSrcA   = 1'b1;
            aluOp     = 2'b10;
            stateNext = RWB;
         end

         RWB: begin
            regWrite  = 1'b1;
            regDst    = 1'b1;
            stateNext = FETCH;
         end

         BEQ: begin
            aluSrcA     = 1'b1;
            aluOp       = 2'b01;
            pcWriteCond = 1'b1;
            pcSource    = 2'b01;
            stateNext   = FETCH;
         end

         JMP: begin
            pcWrite   = 1'b1;
            pcSource  = 2'b10;
            stateNext = FETCH;
         end

`ifdef MC_MAIN_CTRL_ADDI_EN
         ADDIEX: begin
            aluSrcA   = 1'b1;
            aluSrcB   = 2'b10;
            stateNext = ADDIWB;
         end

         ADDIWB: begin
            regWrite  = 1'b1;
            stateNext = FETCH;
         end
`endif

         default: begin
            illegal_op = 1'b1;
            stateNext  = FETCH;
         end
      endcase
   end

endmodule
